alu_driver: RTL and testbench

Issue-side front end for the RV32I ALU: accepts operand/opcode requests over a valid/ready handshake, buffers them in a small FIFO, drives the combinational ALU's `src_A`/`src_B`/`alu_op` inputs one request per cycle, and captures `alu_result`/`alu_zero` into a registered response with backpressure. It also translates branch requests (funct3) into ALU compare ops and resolves the taken decision from the ALU outputs. It sits between decode/issue logic and the ALU, and lets multi-cycle or stalling consumers use the ALU without combinational paths through it.

---
 rtl/alu_driver.sv | 182 ++++++++++++++++++
 tb/tb_alu_driver.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_driver.sv
// ALU issue front end: request FIFO, ALU port drive, registered response.
// Define ALU_DRIVER_BYPASS_EN to let a request skip an empty FIFO.
module alu_driver #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic [3:0]  req_op,
  input  logic        req_branch,
  input  logic [2:0]  req_funct3,
  input  logic [3:0]  req_tag,
  output logic [31:0] alu_src_A,
  output logic [31:0] alu_src_B,
  output logic [3:0]  alu_op,
  input  logic [31:0] alu_result,
  input  logic        alu_zero,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic        rsp_zero,
  output logic        rsp_taken,
  output logic [3:0]  rsp_tag,
  output logic        busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_SLT  = 4'b0101;
  localparam logic [3:0] OP_SLTU = 4'b0110;
  localparam logic [3:0] OP_NOP  = 4'b1111;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic        branch;
    logic [2:0]  funct3;
    logic [3:0]  tag;
  } req_t;

  req_t          r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic          r_rsp_valid;
  logic [31:0]   r_rsp_result;
  logic          r_rsp_zero;
  logic          r_rsp_taken;
  logic [3:0]    r_rsp_tag;

  req_t          w_req_in;
  req_t          w_sel;
  logic          w_full;
  logic          w_empty;
  logic          w_slot_free;
  logic          w_issue_fifo;
  logic          w_bypass;
  logic          w_fire;
  logic          w_push;
  logic          w_pop;
  logic          w_taken;

  function automatic logic [3:0] br_op(input logic [2:0] f3);
    logic [3:0] op;
    case (f3)
      3'b100, 3'b101: op = OP_SLT;
      3'b110, 3'b111: op = OP_SLTU;
      default:        op = OP_SUB;
    endcase
    return op;
  endfunction

  function automatic logic br_taken(
    input logic [2:0] f3,
    input logic       lsb,
    input logic       zero
  );
    logic t;
    case (f3)
      3'b000:         t = zero;
      3'b001:         t = !zero;
      3'b100, 3'b110: t = lsb;
      3'b101, 3'b111: t = !lsb;
      default:        t = 1'b0;
    endcase
    return t;
  endfunction

  assign w_req_in = '{
    a:      req_a,
    b:      req_b,
    op:     req_op,
    branch: req_branch,
    funct3: req_funct3,
    tag:    req_tag
  };

  assign w_full      = (r_count == CW'(FIFO_DEPTH));
  assign w_empty     = (r_count == '0);
  assign w_slot_free = !r_rsp_valid || rsp_ready;
  assign w_issue_fifo = !w_empty && w_slot_free;

`ifdef ALU_DRIVER_BYPASS_EN
  assign w_bypass = w_empty && w_slot_free && req_valid;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_fire = w_issue_fifo || w_bypass;
  assign w_pop  = w_issue_fifo;
  // Full blocks acceptance even when the head pops this cycle
  assign w_push = req_valid && !w_full && !w_bypass;
  assign w_sel  = w_issue_fifo ? r_mem[r_rd_ptr] : w_req_in;

  always_comb begin
    alu_src_A = '0;
    alu_src_B = '0;
    alu_op    = OP_NOP;
    if (w_fire) begin
      alu_src_A = w_sel.a;
      alu_src_B = w_sel.b;
      alu_op    = w_sel.branch ? br_op(w_sel.funct3) : w_sel.op;
    end
  end

  assign w_taken = w_sel.branch &&
    br_taken(w_sel.funct3, alu_result[0], alu_zero);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_req_in;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rsp_valid  <= 1'b0;
      r_rsp_result <= '0;
      r_rsp_zero   <= 1'b0;
      r_rsp_taken  <= 1'b0;
      r_rsp_tag    <= '0;
    end else if (w_fire) begin
      r_rsp_valid  <= 1'b1;
      r_rsp_result <= alu_result;
      r_rsp_zero   <= alu_zero;
      r_rsp_taken  <= w_taken;
      r_rsp_tag    <= w_sel.tag;
    end else if (rsp_ready) begin
      r_rsp_valid  <= 1'b0;
    end
  end

  assign req_ready  = !w_full;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_result = r_rsp_result;
  assign rsp_zero   = r_rsp_zero;
  assign rsp_taken  = r_rsp_taken;
  assign rsp_tag    = r_rsp_tag;
  assign busy       = !w_empty || r_rsp_valid;

endmodule

// File: tb/tb_alu_driver.sv
// Directed bench for alu_driver with a small behavioural ALU model.
// Honours ALU_DRIVER_BYPASS_EN for latency expectations.
module tb_alu_driver;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [3:0]  req_op;
  logic        req_branch;
  logic [2:0]  req_funct3;
  logic [3:0]  req_tag;
  logic [31:0] alu_src_A;
  logic [31:0] alu_src_B;
  logic [3:0]  alu_op;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic        rsp_zero;
  logic        rsp_taken;
  logic [3:0]  rsp_tag;
  logic        busy;

  int n_chk  = 0;
  int n_fail = 0;

`ifdef ALU_DRIVER_BYPASS_EN
  localparam int EXP_WAIT = 0;
`else
  localparam int EXP_WAIT = 1;
`endif

  always #5 clk = ~clk;

  alu_driver #(.FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_op     (req_op),
    .req_branch (req_branch),
    .req_funct3 (req_funct3),
    .req_tag    (req_tag),
    .alu_src_A  (alu_src_A),
    .alu_src_B  (alu_src_B),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .alu_zero   (alu_zero),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_zero   (rsp_zero),
    .rsp_taken  (rsp_taken),
    .rsp_tag    (rsp_tag),
    .busy       (busy)
  );

  always_comb begin
    alu_result = '0;
    case (alu_op)
      4'b0000: alu_result = alu_src_A + alu_src_B;
      4'b0001: alu_result = alu_src_A - alu_src_B;
      4'b0101: alu_result = {31'b0, $signed(alu_src_A) < $signed(alu_src_B)};
      4'b0110: alu_result = {31'b0, alu_src_A < alu_src_B};
      default: alu_result = '0;
    endcase
  end
  assign alu_zero = (alu_result == 32'd0);

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input string tag, input logic [31:0] a,
                      input logic [31:0] b, input logic [3:0] op,
                      input logic br, input logic [2:0] f3,
                      input logic [3:0] tg, input logic [3:0] exp_op);
    req_a      = a;
    req_b      = b;
    req_op     = op;
    req_branch = br;
    req_funct3 = f3;
    req_tag    = tg;
    req_valid  = 1'b1;
`ifdef ALU_DRIVER_BYPASS_EN
    #1;
    chk({tag, "_aluop"}, 32'(alu_op), 32'(exp_op));
`endif
    tick;
    req_valid = 1'b0;
`ifndef ALU_DRIVER_BYPASS_EN
    chk({tag, "_aluop"}, 32'(alu_op), 32'(exp_op));
`endif
  endtask

  task automatic get_rsp(input string tag, input logic [31:0] res,
                         input logic z, input logic t,
                         input logic [3:0] tg, output int waited);
    int k;
    k = 0;
    while (!rsp_valid && k < 8) begin
      tick;
      k++;
    end
    waited = k;
    chk({tag, "_valid"}, 32'(rsp_valid), 32'd1);
    chk({tag, "_result"}, rsp_result, res);
    chk({tag, "_zero"}, 32'(rsp_zero), 32'(z));
    chk({tag, "_taken"}, 32'(rsp_taken), 32'(t));
    chk({tag, "_tag"}, 32'(rsp_tag), 32'(tg));
    tick;
  endtask

  initial begin
    int w;
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int k;
    reset_n    = 1'b0;
    req_valid  = 1'b0;
    req_a      = '0;
    req_b      = '0;
    req_op     = '0;
    req_branch = 1'b0;
    req_funct3 = '0;
    req_tag    = '0;
    rsp_ready  = 1'b1;
    repeat (2) tick;

    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_result", rsp_result, 32'd0);
    chk("rst_rsp_tag", 32'(rsp_tag), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_alu_op", 32'(alu_op), 32'hF);
    chk("rst_src_a", alu_src_A, 32'd0);
    reset_n = 1'b1;
    tick;

    send("add", 32'd5, 32'd7, 4'b0000, 1'b0, 3'b000, 4'd3, 4'b0000);
    get_rsp("add", 32'd12, 1'b0, 1'b0, 4'd3, w);
    chk("add_latency", 32'(w), 32'(EXP_WAIT));
    chk("idle_valid", 32'(rsp_valid), 32'd0);
    chk("idle_op", 32'(alu_op), 32'hF);

    send("blt", 32'hFFFF_FFFF, 32'd1, 4'b0000, 1'b1, 3'b100, 4'd1, 4'b0101);
    get_rsp("blt", 32'd1, 1'b0, 1'b1, 4'd1, w);
    send("bgeu", 32'hFFFF_FFFF, 32'd1, 4'b0000, 1'b1, 3'b111, 4'd2, 4'b0110);
    get_rsp("bgeu", 32'd0, 1'b1, 1'b1, 4'd2, w);
    send("bge", 32'hFFFF_FFFF, 32'd1, 4'b0000, 1'b1, 3'b101, 4'd4, 4'b0101);
    get_rsp("bge", 32'd1, 1'b0, 1'b0, 4'd4, w);
    send("bltu", 32'hFFFF_FFFF, 32'd1, 4'b0000, 1'b1, 3'b110, 4'd5, 4'b0110);
    get_rsp("bltu", 32'd0, 1'b1, 1'b0, 4'd5, w);
    send("sub", 32'h1234, 32'h1234, 4'b0001, 1'b0, 3'b000, 4'd6, 4'b0001);
    get_rsp("sub", 32'd0, 1'b1, 1'b0, 4'd6, w);
    send("bne", 32'h1234, 32'h1234, 4'b0000, 1'b1, 3'b001, 4'd7, 4'b0001);
    get_rsp("bne", 32'd0, 1'b1, 1'b0, 4'd7, w);
    send("beq", 32'h1234, 32'h1234, 4'b0000, 1'b1, 3'b000, 4'd8, 4'b0001);
    get_rsp("beq", 32'd0, 1'b1, 1'b1, 4'd8, w);
    send("ill", 32'd1, 32'd2, 4'b0000, 1'b1, 3'b010, 4'd9, 4'b0001);
    get_rsp("ill", 32'hFFFF_FFFF, 1'b0, 1'b0, 4'd9, w);

    rsp_ready  = 1'b0;
    req_op     = 4'b0000;
    req_branch = 1'b0;
    req_b      = 32'd0;
    for (int i = 0; i < 5; i++) begin
      req_a     = 32'(i);
      req_tag   = 4'(i);
      req_valid = 1'b1;
      tick;
    end
    req_a   = 32'd5;
    req_tag = 4'd5;
    chk("bp_req_ready", 32'(req_ready), 32'd0);
    tick;
    req_valid = 1'b0;
    chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("bp_busy", 32'(busy), 32'd1);
    chk("bp_hold_op", 32'(alu_op), 32'hF);
    tick;
    chk("bp_hold_tag", 32'(rsp_tag), 32'd0);
    rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_drain_valid", 32'(rsp_valid), 32'd1);
      chk("bp_drain_tag", 32'(rsp_tag), 32'(i));
      chk("bp_drain_result", rsp_result, 32'(i));
      tick;
    end
    chk("bp_end_valid", 32'(rsp_valid), 32'd0);
    chk("bp_end_busy", 32'(busy), 32'd0);

    for (int i = 0; i < 6; i++) begin
      req_valid = (i < 4);
      req_a     = 32'(i + 10);
      req_tag   = 4'(i + 8);
      tick;
      k = i - EXP_WAIT;
      if (k >= 0 && k < 4) begin
        chk("st_valid", 32'(rsp_valid), 32'd1);
        chk("st_tag", 32'(rsp_tag), 32'(k + 8));
        chk("st_result", rsp_result, 32'(k + 10));
      end else begin
        chk("st_gap_valid", 32'(rsp_valid), 32'd0);
      end
    end
    req_valid = 1'b0;
    chk("st_idle_op", 32'(alu_op), 32'hF);
    chk("st_idle_a", alu_src_A, 32'd0);
    chk("st_idle_b", alu_src_B, 32'd0);

    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req_valid = 1'b1;
      req_a     = 32'(i);
      req_tag   = 4'(i + 1);
      tick;
    end
    req_valid = 1'b0;
    chk("mr_busy_before", 32'(busy), 32'd1);
    #1;
    reset_n = 1'b0;
    #1;
    chk("mr_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_alu_op", 32'(alu_op), 32'hF);
    chk("mr_req_ready", 32'(req_ready), 32'd1);
    chk("mr_rsp_tag", 32'(rsp_tag), 32'd0);
    tick;
    reset_n   = 1'b1;
    rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("mr_stale_valid", 32'(rsp_valid), 32'd0);
      chk("mr_stale_busy", 32'(busy), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
